// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall (hold), flush (bubble) and valid tracking
module id_ex_reg #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [1:0]          jump,
  input  logic                branch,
  input  logic                mem_read,
  input  logic                mem_to_reg,
  input  logic                mem_write,
  input  logic                alu_src,
  input  logic                reg_write,
  input  logic                reg_dst,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]   pc_plus4,
  input  logic [DATA_W-1:0]   r_data1,
  input  logic [DATA_W-1:0]   r_data2,
  input  logic [DATA_W-1:0]   imm,
  input  logic [REG_W-1:0]    rs,
  input  logic [REG_W-1:0]    rt,
  input  logic [REG_W-1:0]    rd,
  input  logic [4:0]          shamt,
  output logic                valid_out,
  output logic [1:0]          jump_out,
  output logic                branch_out,
  output logic                mem_read_out,
  output logic                mem_to_reg_out,
  output logic                mem_write_out,
  output logic                alu_src_out,
  output logic                reg_write_out,
  output logic                reg_dst_out,
  output logic [ALU_OP_W-1:0] alu_op_out,
  output logic [DATA_W-1:0]   pc_plus4_out,
  output logic [DATA_W-1:0]   r_data1_out,
  output logic [DATA_W-1:0]   r_data2_out,
  output logic [DATA_W-1:0]   imm_out,
  output logic [REG_W-1:0]    rs_out,
  output logic [REG_W-1:0]    rt_out,
  output logic [REG_W-1:0]    rd_out,
  output logic [4:0]          shamt_out
);
  localparam int W = 1 + 2 + 7 + ALU_OP_W + 4 * DATA_W + 3 * REG_W + 5;
  logic [W-1:0] d, q;
  assign d = {valid_in, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst,
              alu_op, pc_plus4, r_data1, r_data2, imm, rs, rt, rd, shamt};
  assign {valid_out, jump_out, branch_out, mem_read_out, mem_to_reg_out, mem_write_out, alu_src_out,
          reg_write_out, reg_dst_out, alu_op_out, pc_plus4_out, r_data1_out, r_data2_out, imm_out,
          rs_out, rt_out, rd_out, shamt_out} = q;
  // Whole stage word: flush zeroes it (beating stall), stall holds it, otherwise load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (flush) q <= '0;
    else if (!stall) q <= d;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized self-checking bench for the ID/EX pipeline register
module tb_id_ex_reg;
  typedef struct packed {
    logic        valid;
    logic [1:0]  jump;
    logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst;
    logic [3:0]  alu_op;
    logic [31:0] pc_plus4, r_data1, r_data2, imm;
    logic [4:0]  rs, rt, rd, shamt;
  } word_t;

  logic clk = 0, rst_n, stall, flush;
  word_t din, exp, obs;
  int total = 0, bad = 0;

  logic        valid_out, branch_out, mem_read_out, mem_to_reg_out, mem_write_out;
  logic        alu_src_out, reg_write_out, reg_dst_out;
  logic [1:0]  jump_out;
  logic [3:0]  alu_op_out;
  logic [31:0] pc_plus4_out, r_data1_out, r_data2_out, imm_out;
  logic [4:0]  rs_out, rt_out, rd_out, shamt_out;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(din.valid),
    .jump(din.jump), .branch(din.branch), .mem_read(din.mem_read), .mem_to_reg(din.mem_to_reg),
    .mem_write(din.mem_write), .alu_src(din.alu_src), .reg_write(din.reg_write),
    .reg_dst(din.reg_dst), .alu_op(din.alu_op), .pc_plus4(din.pc_plus4), .r_data1(din.r_data1),
    .r_data2(din.r_data2), .imm(din.imm), .rs(din.rs), .rt(din.rt), .rd(din.rd), .shamt(din.shamt),
    .valid_out(valid_out), .jump_out(jump_out), .branch_out(branch_out),
    .mem_read_out(mem_read_out), .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out),
    .alu_src_out(alu_src_out), .reg_write_out(reg_write_out), .reg_dst_out(reg_dst_out),
    .alu_op_out(alu_op_out), .pc_plus4_out(pc_plus4_out), .r_data1_out(r_data1_out),
    .r_data2_out(r_data2_out), .imm_out(imm_out), .rs_out(rs_out), .rt_out(rt_out),
    .rd_out(rd_out), .shamt_out(shamt_out)
  );

  assign obs = {valid_out, jump_out, branch_out, mem_read_out, mem_to_reg_out, mem_write_out,
                alu_src_out, reg_write_out, reg_dst_out, alu_op_out, pc_plus4_out, r_data1_out,
                r_data2_out, imm_out, rs_out, rt_out, rd_out, shamt_out};

  task automatic rand_in();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    din = r[$bits(word_t)-1:0];
  endtask

  // One rising edge; the reference is the stage rule: reset/flush give a bubble, stall keeps, else take input
  task automatic cyc(input logic st, input logic fl);
    stall = st;
    flush = fl;
    @(posedge clk);
    if (rst_n) exp = fl ? '0 : (st ? exp : din);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; flush = 0; exp = '0;
    rand_in(); din.alu_op = 4'hA; din.r_data1 = 32'hDEADBEEF;
    #1;
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_initial got=%h want=%h", obs, exp); end
    #2 rst_n = 1;
    cyc(0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_first_load got=%h want=%h", obs, exp); end
    #2 rst_n = 0; exp = '0;
    #1;
    total++; if (obs !== exp) begin bad++; $display("FAIL reset_async got=%h want=%h", obs, exp); end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0);
      total++; if (obs !== '0) begin bad++; $display("FAIL reset_held got=%h want=0", obs); end
    end
    rst_n = 1;
    cyc(0, 0);
    total++; if (obs !== din) begin bad++; $display("FAIL reset_release got=%h want=%h", obs, din); end
  endtask

  task automatic test_load();
    din = '0; din.reg_write = 1; din.alu_src = 1; din.alu_op = 4'h2;
    din.imm = 32'hFFFF_FFFC; din.rt = 5'd9; din.valid = 1;
    cyc(0, 0);
    total++; if (obs !== exp) begin bad++; $display("FAIL load_directed got=%h want=%h", obs, exp); end
    total++; if (imm_out !== 32'hFFFF_FFFC || rt_out !== 5'd9 || valid_out !== 1'b1)
      begin bad++; $display("FAIL load_fields imm=%h rt=%0d v=%b want imm=fffffffc rt=9 v=1", imm_out, rt_out, valid_out); end
    for (int i = 0; i < 10; i++) begin
      rand_in();
      cyc(0, 0);
      total++; if (obs !== exp) begin bad++; $display("FAIL load_track got=%h want=%h", obs, exp); end
    end
  endtask

  task automatic test_stall_hold();
    rand_in(); din.r_data2 = 32'h0000_1234;
    cyc(0, 0);
    din.r_data2 = 32'hAAAA_5555;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0);
      total++; if (r_data2_out !== 32'h0000_1234 || obs !== exp)
        begin bad++; $display("FAIL stall_hold got=%h want=%h", obs, exp); end
    end
    cyc(0, 0);
    total++; if (r_data2_out !== 32'hAAAA_5555) begin bad++; $display("FAIL stall_release got=%h want=aaaa5555", r_data2_out); end
  endtask

  task automatic test_flush();
    rand_in(); din.mem_write = 1; din.jump = 2'b10; din.valid = 1;
    cyc(0, 1);
    total++; if (obs !== '0 || valid_out !== 1'b0) begin bad++; $display("FAIL flush got=%h want=0", obs); end
  endtask

  task automatic test_stall_flush();
    rand_in(); din.reg_write = 1; din.valid = 1;
    cyc(0, 0);
    total++; if (reg_write_out !== 1'b1) begin bad++; $display("FAIL stall_flush_pre got=%b want=1", reg_write_out); end
    rand_in();
    cyc(1, 1);
    total++; if (obs !== '0 || valid_out !== 1'b0) begin bad++; $display("FAIL stall_flush got=%h want=0", obs); end
  endtask

  task automatic test_reset_mid_stall();
    rand_in(); din.pc_plus4 = 32'h0040_0010;
    cyc(0, 0);
    rand_in();
    cyc(1, 0);
    total++; if (pc_plus4_out !== 32'h0040_0010) begin bad++; $display("FAIL mid_stall_hold got=%h want=00400010", pc_plus4_out); end
    #2 rst_n = 0; exp = '0;
    #1;
    total++; if (obs !== '0) begin bad++; $display("FAIL mid_stall_reset got=%h want=0", obs); end
    #1 rst_n = 1;
    cyc(0, 0);
    total++; if (obs !== din) begin bad++; $display("FAIL mid_stall_reload got=%h want=%h", obs, din); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_in();
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
      total++; if (obs !== exp) begin bad++; $display("FAIL random[%0d] got=%h want=%h", i, obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall_hold();
    test_flush();
    test_stall_flush();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
